// File: rtl/core_fetch.sv
// Instruction fetch stage for the 8085-style core: runs the byte-wide memory
// read cycle, owns the PC and presents whole instructions to execute.
module core_fetch #(
    parameter int unsigned          DATASIZE = 8,
    parameter int unsigned          ADDRSIZE = 16,
    parameter logic [ADDRSIZE-1:0]  RESETPC  = ADDRSIZE'(0)
) (
    input  logic                clk,
    input  logic                rst,
    output logic [ADDRSIZE-1:0] addr,
    output logic                rd_n,
    input  logic                ready,
    input  logic [DATASIZE-1:0] din,
    output logic                ival,
    input  logic                iack,
    output logic [DATASIZE-1:0] iopc,
    output logic [DATASIZE-1:0] iop1,
    output logic [DATASIZE-1:0] iop2,
    output logic [1:0]          ilen,
    output logic [ADDRSIZE-1:0] ipc,
    input  logic                pcwr,
    input  logic [ADDRSIZE-1:0] pcdat,
    output logic [ADDRSIZE-1:0] pc
);

    localparam logic [1:0] ST_T1   = 2'd0;
    localparam logic [1:0] ST_T2   = 2'd1;
    localparam logic [1:0] ST_T3   = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [ADDRSIZE-1:0] pc_q, pc_d;
    logic [ADDRSIZE-1:0] addr_q, addr_d;
    logic [ADDRSIZE-1:0] ipc_q, ipc_d;
    logic                rd_n_q, rd_n_d;
    logic                ival_q, ival_d;
    logic [DATASIZE-1:0] iopc_q, iopc_d;
    logic [DATASIZE-1:0] iop1_q, iop1_d;
    logic [DATASIZE-1:0] iop2_q, iop2_d;
    logic [1:0]          ilen_q, ilen_d;
    logic [1:0]          cnt_q, cnt_d;

    logic [1:0]          dec_len_c;
    logic [1:0]          cur_len_c;
    logic [1:0]          cnt_inc_c;
    logic [ADDRSIZE-1:0] pc_inc_c;

    // Instruction length from the opcode byte; anything unlisted is one byte.
    always_comb begin
        dec_len_c = 2'd1;
        casez (din[7:0])
            8'b00??0001,
            8'b001??010,
            8'b11???010,
            8'b11000011,
            8'b11???100,
            8'b11001101: dec_len_c = 2'd3;
            8'b00???110,
            8'b11???110,
            8'b11010011,
            8'b11011011: dec_len_c = 2'd2;
            default:     dec_len_c = 2'd1;
        endcase
    end

    assign cnt_inc_c = cnt_q + 2'd1;
    assign pc_inc_c  = pc_q + ADDRSIZE'(1);
    assign cur_len_c = (cnt_q == 2'd0) ? dec_len_c : ilen_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        ipc_d   = ipc_q;
        rd_n_d  = rd_n_q;
        ival_d  = ival_q;
        iopc_d  = iopc_q;
        iop1_d  = iop1_q;
        iop2_d  = iop2_q;
        ilen_d  = ilen_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_T1: begin
                state_d = ST_T2;
                rd_n_d  = 1'b0;
            end
            ST_T2: begin
                if (ready) begin
                    state_d = ST_T3;
                end
            end
            ST_T3: begin
                case (cnt_q)
                    2'd0:    iopc_d = din;
                    2'd1:    iop1_d = din;
                    default: iop2_d = din;
                endcase
                if (cnt_q == 2'd0) begin
                    ipc_d  = pc_q;
                    ilen_d = dec_len_c;
                end
                pc_d   = pc_inc_c;
                rd_n_d = 1'b1;
                cnt_d  = cnt_inc_c;
                if (cnt_inc_c == cur_len_c) begin
                    state_d = ST_HOLD;
                    ival_d  = 1'b1;
                end else begin
                    state_d = ST_T1;
                    addr_d  = pc_inc_c;
                end
            end
            default: begin
                // No prefetch: the next opcode read starts only after acceptance.
                if (iack) begin
                    state_d = ST_T1;
                    ival_d  = 1'b0;
                    cnt_d   = 2'd0;
                    addr_d  = pc_q;
                end
            end
        endcase

        // A PC load overrides everything, abandoning any partial fetch.
        if (pcwr) begin
            state_d = ST_T1;
            pc_d    = pcdat;
            addr_d  = pcdat;
            cnt_d   = 2'd0;
            ival_d  = 1'b0;
            rd_n_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_T1;
            pc_q    <= RESETPC;
            addr_q  <= RESETPC;
            ipc_q   <= RESETPC;
            rd_n_q  <= 1'b1;
            ival_q  <= 1'b0;
            iopc_q  <= '0;
            iop1_q  <= '0;
            iop2_q  <= '0;
            ilen_q  <= 2'd0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ipc_q   <= ipc_d;
            rd_n_q  <= rd_n_d;
            ival_q  <= ival_d;
            iopc_q  <= iopc_d;
            iop1_q  <= iop1_d;
            iop2_q  <= iop2_d;
            ilen_q  <= ilen_d;
            cnt_q   <= cnt_d;
        end
    end

    assign addr = addr_q;
    assign rd_n = rd_n_q;
    assign ival = ival_q;
    assign iopc = iopc_q;
    assign iop1 = iop1_q;
    assign iop2 = iop2_q;
    assign ilen = ilen_q;
    assign ipc  = ipc_q;
    assign pc   = pc_q;

endmodule

// File: doc/core_fetch.md
Name: core_fetch

Overview:
- Instruction fetch stage directly upstream of the ALU/register-file block in the 8085-style core.
- Drives the external byte-wide memory read cycle and owns the program counter.
- Fetches the opcode and up to two operand bytes, computing instruction length from the opcode.
- Presents the complete instruction to the execute stage with a valid/acknowledge handshake, and accepts PC loads for jumps, calls and returns.

Parameters:
DATASIZE, 8, data/opcode width
ADDRSIZE, 16, address and PC width
RESETPC, 16'h0000, PC value after reset

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  asynchronous active-low reset
addr  output  ADDRSIZE  memory address
rd_n  output  1  active-low read strobe
ready  input  1  memory ready, sampled in T2
din  input  DATASIZE  memory read data
ival  output  1  instruction valid
iack  input  1  execute stage accepts instruction
iopc  output  DATASIZE  opcode
iop1  output  DATASIZE  operand byte 1 (low/immediate)
iop2  output  DATASIZE  operand byte 2 (high)
ilen  output  2  instruction length 1..3
ipc  output  ADDRSIZE  address of the opcode byte
pcwr  input  1  load PC (branch/flush)
pcdat  input  ADDRSIZE  new PC value
pc  output  ADDRSIZE  current PC

Behaviour:
- Reset (rst=0, async): state=T1, pc=addr=ipc=RESETPC, rd_n=1, ival=0, iopc=iop1=iop2=0, ilen=0, byte counter=0.
- States: T1, T2, T3, HOLD.
- T1: addr=pc, rd_n=1; next T2.
- T2: rd_n=0; ready=1 -> T3, else stay in T2 (wait states, unbounded).
- T3: rd_n=0.
  - At the closing edge: latch din into the slot selected by the byte counter (0=iopc, 1=iop1, 2=iop2), pc<=pc+1 (wraps FFFF->0000), rd_n returns 1.
  - Byte 0 only: ipc<=pc and ilen<=decoded length.
  - Next state: if bytes fetched == length -> HOLD with ival=1, else T1 for the next byte.
- addr holds pc, stable from T1 through T3.
- HOLD: ival=1 and outputs stable; rd_n=1. On iack=1: ival<=0, counter<=0, next T1. Fetch of the next instruction begins the cycle after acceptance (no prefetch).
- Length decode on the opcode:
  - 3 bytes: 00xx0001 (LXI); 001xx010 (SHLD/LHLD/STA/LDA); 11xxx010; 11000011; 11xxx100; 11001101.
  - 2 bytes: 00xxx110 (MVI); 11xxx110; 11010011; 11011011.
  - 1 byte: all others.
  - Undefined opcodes follow the same table; no trap.
- Minimum fetch latency: 3 cycles per byte, so 3/6/9 cycles from the first T1 to HOLD.
- pcwr=1 in any state has priority:
  - pc<=pcdat, state<=T1, counter<=0, ival<=0, rd_n<=1.
  - A partial fetch is abandoned and partially latched bytes are discarded.
- pcwr together with iack in HOLD: the instruction counts as accepted and the PC load applies. Fetch resumes at pcdat.
- iack outside HOLD is ignored.
- ready is ignored outside T2.
- Reset asserted mid-cycle: immediate return to reset values; rd_n deasserts asynchronously.
- Operand slots not used by a shorter instruction keep their previous values; consumers must use ilen.

Test Plan:
- Reset release, PC=0000, mem[0]=3E, mem[1]=55, ready=1 -> ival rises 6 cycles after the first T1; iopc=3E, iop1=55, ilen=2, ipc=0000, pc=0002.
- mem[0]=C3, 34, 12, ready=1, iack held 0 -> ival=1 after 9 cycles and held; iop1=34, iop2=12, ilen=3; rd_n stays 1 in HOLD. Pulse iack -> ival=0 next cycle, T1 with addr=0003.
- 1-byte NOP (00) with ready=0 for 4 cycles in T2 -> rd_n low for 5 cycles (T2×5 incl. ready cycle) plus T3; ival rises after 7 cycles; ilen=1.
- pcwr=1, pcdat=8000 during T2 of byte 2 of an LXI -> ival stays 0, next cycle T1 with addr=8000, counter restarts; the old opcode is not presented.
- PC=FFFF, mem[FFFF]=00 -> after T3, pc=0000, ipc=FFFF.
- In HOLD, assert iack and pcwr=1 (pcdat=0100) together -> ival=0, next T1 at addr=0100; rst pulsed low mid-T2 -> rd_n=1 and pc=RESETPC immediately.
